// File: rtl/phase_shift_sequencer.sv
// Multi-PLL dynamic phase-shift sequencer: one held phasestep pulse per step, each closed by a phasedone low/high handshake.
// Defining PHASE_SHIFT_TIMEOUT_EN adds a per-step watchdog that aborts a step that never completes.
module phase_shift_sequencer #(
   parameter int NUM_PLLS       = 4,
   parameter int SEL_W          = 2,
   parameter int CNT_W          = 8,
   parameter int CNTSEL_W       = 5,
   parameter int STEP_HOLD      = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [SEL_W-1:0]    i_pll_idx,
   input  logic [CNT_W-1:0]    i_steps,
   input  logic                i_updown,
   input  logic [CNTSEL_W-1:0] i_cntsel,
   input  logic [NUM_PLLS-1:0] i_phasedone,
   output logic [NUM_PLLS-1:0] o_phasestep,
   output logic                o_phaseupdown,
   output logic [CNTSEL_W-1:0] o_cntsel,
   output logic                o_busy,
   output logic [CNT_W-1:0]    o_steps_done,
   output logic                o_done,
   output logic                o_error
);

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT_HIGH, S_DONE} state_t;

   localparam int PAD_W  = 1 << SEL_W;
   localparam int HOLD_W = $clog2(STEP_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(STEP_HOLD);

   state_t              state, state_n;
   logic [NUM_PLLS-1:0] pd_sync_p0, pd_sync_p1;
   logic [PAD_W-1:0]    pd_vec;
   logic                pd;
   logic [SEL_W-1:0]    idx_lat, idx_n;
   logic [CNT_W-1:0]    steps_lat, steps_n, done_cnt_n;
   logic                updown_n, error_n;
   logic [CNTSEL_W-1:0] cntsel_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_n;

`ifdef PHASE_SHIFT_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_cnt, wd_n;
   logic            wd_hit;
   assign wd_hit = ((state == S_STEP) || (state == S_WAIT_HIGH)) && (wd_cnt == WD_LAST);
`endif

   // Zero-padded so an out-of-range latched index never selects outside the vector.
   assign pd_vec = PAD_W'(pd_sync_p1);
   assign pd     = pd_vec[idx_lat];

   always_comb begin
      state_n    = state;
      idx_n      = idx_lat;
      steps_n    = steps_lat;
      updown_n   = o_phaseupdown;
      cntsel_n   = o_cntsel;
      done_cnt_n = o_steps_done;
      hold_n     = hold_cnt;
      error_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_valid) begin
               idx_n      = i_pll_idx;
               steps_n    = i_steps;
               updown_n   = i_updown;
               cntsel_n   = i_cntsel;
               done_cnt_n = '0;
               if (int'(i_pll_idx) >= NUM_PLLS) begin
                  state_n = S_DONE;
                  error_n = 1'b1;
               end else if (i_steps == '0) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_STEP;
               end
            end
         end
         S_STEP: begin
            if (hold_cnt < HOLD_MIN) hold_n = hold_cnt + 1'b1;
            if ((hold_cnt >= HOLD_MIN) && !pd) state_n = S_WAIT_HIGH;
         end
         S_WAIT_HIGH: begin
            if (pd) begin
               done_cnt_n = o_steps_done + 1'b1;
               state_n    = (done_cnt_n == steps_lat) ? S_DONE : S_STEP;
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // Hold count starts at 1 so the first STEP cycle already counts toward STEP_HOLD.
      if ((state_n == S_STEP) && (state != S_STEP)) hold_n = HOLD_W'(1);
`ifdef PHASE_SHIFT_TIMEOUT_EN
      wd_n = wd_cnt;
      if ((state_n == S_STEP) && (state != S_STEP)) begin
         wd_n = '0;
      end else if ((state == S_STEP) || (state == S_WAIT_HIGH)) begin
         wd_n = wd_cnt + 1'b1;
      end
      if (wd_hit && (state_n != S_DONE)) begin
         state_n = S_DONE;
         error_n = 1'b1;
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ready       <= 1'b1;
         o_busy        <= 1'b0;
         o_phasestep   <= '0;
         o_phaseupdown <= 1'b0;
         o_cntsel      <= '0;
         o_steps_done  <= '0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
      end else begin
         o_ready       <= (state_n == S_IDLE);
         o_busy        <= (state_n != S_IDLE);
         o_phasestep   <= (state_n == S_STEP) ? (NUM_PLLS'(1) << idx_n) : '0;
         o_phaseupdown <= updown_n;
         o_cntsel      <= cntsel_n;
         o_steps_done  <= done_cnt_n;
         o_done        <= (state_n == S_DONE);
         o_error       <= error_n;
      end
   end

   // Synchroniser stages and request data; always rewritten before use, so no reset.
   always_ff @(posedge i_clk) begin
      pd_sync_p0 <= i_phasedone;
      pd_sync_p1 <= pd_sync_p0;
      idx_lat    <= idx_n;
      steps_lat  <= steps_n;
      hold_cnt   <= hold_n;
`ifdef PHASE_SHIFT_TIMEOUT_EN
      wd_cnt     <= wd_n;
`endif
   end

endmodule

// File: tb/tb_phase_shift_sequencer.sv
// Scoreboard bench for phase_shift_sequencer: randomized requests against a behavioural PLL model and per-request expectations.
module tb_phase_shift_sequencer;
   localparam int NUM_PLLS       = 4;
   localparam int SEL_W          = 3;
   localparam int CNT_W          = 8;
   localparam int CNTSEL_W       = 5;
   localparam int STEP_HOLD      = 2;
   localparam int TIMEOUT_CYCLES = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                valid;
   logic                ready;
   logic [SEL_W-1:0]    pll_idx;
   logic [CNT_W-1:0]    steps;
   logic                updown;
   logic [CNTSEL_W-1:0] cntsel;
   logic [NUM_PLLS-1:0] phasedone;
   logic [NUM_PLLS-1:0] phasestep;
   logic                phaseupdown;
   logic [CNTSEL_W-1:0] cntsel_o;
   logic                busy;
   logic [CNT_W-1:0]    steps_done;
   logic                done;
   logic                error;

   always #5 clk = ~clk;

   phase_shift_sequencer #(
      .NUM_PLLS(NUM_PLLS), .SEL_W(SEL_W), .CNT_W(CNT_W), .CNTSEL_W(CNTSEL_W),
      .STEP_HOLD(STEP_HOLD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
      .i_pll_idx(pll_idx), .i_steps(steps), .i_updown(updown), .i_cntsel(cntsel),
      .i_phasedone(phasedone), .o_phasestep(phasestep), .o_phaseupdown(phaseupdown),
      .o_cntsel(cntsel_o), .o_busy(busy), .o_steps_done(steps_done),
      .o_done(done), .o_error(error)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // PLL model: phasedone drops drop_dly cycles after phasestep rises, rises rise_dly cycles later.
   int                  drop_dly = 3;
   int                  rise_dly = 4;
   int                  ph [NUM_PLLS];
   int                  cnt[NUM_PLLS];
   logic [NUM_PLLS-1:0] prev_ps  = '0;
   logic [NUM_PLLS-1:0] model_pd = '1;
   logic                manual_en = 1'b0;
   logic [NUM_PLLS-1:0] manual_pd = '1;

   initial for (int i = 0; i < NUM_PLLS; i++) begin ph[i] = 0; cnt[i] = 0; end

   always @(posedge clk) begin
      for (int i = 0; i < NUM_PLLS; i++) begin
         case (ph[i])
            0: if (phasestep[i] && !prev_ps[i]) begin ph[i] <= 1; cnt[i] <= drop_dly; end
            1: if (cnt[i] <= 1) begin model_pd[i] <= 1'b0; ph[i] <= 2; cnt[i] <= rise_dly; end
               else cnt[i] <= cnt[i] - 1;
            default: if (cnt[i] <= 1) begin model_pd[i] <= 1'b1; ph[i] <= 0; end
               else cnt[i] <= cnt[i] - 1;
         endcase
      end
      prev_ps <= phasestep;
   end

   assign phasedone = manual_en ? manual_pd : model_pd;

   typedef struct {
      int idx; int sd; bit err; bit ud; int cs; int pulses; int exact_w;
   } exp_t;
   exp_t sb[$];

   // Monitor: measures pulses while a request runs, then checks the request record on o_done.
   int   pulse_cnt = 0, cur_w = 0, min_w = 1000, max_w = 0, last_sd = 0;
   bit   stray = 0, attr_bad = 0, seq_bad = 0, post_done = 0;
   logic [NUM_PLLS-1:0] mask;
   exp_t e;

   always @(negedge clk) begin
      if (rst) begin
         pulse_cnt = 0; cur_w = 0; min_w = 1000; max_w = 0; last_sd = 0;
         stray = 0; attr_bad = 0; seq_bad = 0; post_done = 0;
      end else begin
         if (post_done) begin
            check("ready_after_done", ready, 1);
            check("done_one_cycle", done, 0);
            post_done = 0;
         end
         if (valid && ready) begin
            pulse_cnt = 0; cur_w = 0; min_w = 1000; max_w = 0;
            stray = 0; attr_bad = 0; seq_bad = 0;
         end
         if (phasestep != '0) begin
            if (sb.size() == 0) stray = 1;
            else begin
               mask = NUM_PLLS'(1) << sb[0].idx;
               if (phasestep != mask) stray = 1;
               if (phaseupdown != sb[0].ud || int'(cntsel_o) != sb[0].cs) attr_bad = 1;
            end
            cur_w++;
         end else if (cur_w != 0) begin
            pulse_cnt++;
            if (cur_w < min_w) min_w = cur_w;
            if (cur_w > max_w) max_w = cur_w;
            cur_w = 0;
         end
         if (int'(steps_done) != last_sd) begin
            if (steps_done != '0 && int'(steps_done) != last_sd + 1) seq_bad = 1;
            last_sd = int'(steps_done);
         end
         if (done) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL done_unexpected: o_done=1 with no request outstanding");
            end else begin
               e = sb.pop_front();
               check("error_flag", error, e.err);
               check("steps_done", steps_done, e.sd);
               check("pulse_count", pulse_cnt, e.pulses);
               check("phaseupdown", phaseupdown, e.ud);
               check("cntsel", cntsel_o, e.cs);
               check("busy_in_done", busy, 1);
               check("onehot_bit", stray, 0);
               check("attr_stable", attr_bad, 0);
               check("count_sequence", seq_bad, 0);
               if (e.pulses > 0) check("pulse_min_hold", (min_w >= STEP_HOLD), 1);
               if (e.exact_w > 0) begin
                  check("pulse_exact_min", min_w, e.exact_w);
                  check("pulse_exact_max", max_w, e.exact_w);
               end
            end
            post_done = 1;
         end
      end
   end

   task automatic check_reset(input string pfx);
      check({pfx, "_phasestep"}, phasestep, 0);
      check({pfx, "_phaseupdown"}, phaseupdown, 0);
      check({pfx, "_cntsel"}, cntsel_o, 0);
      check({pfx, "_steps_done"}, steps_done, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_error"}, error, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_ready"}, ready, 1);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      @(negedge clk);
      while (!(ready && !busy) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (c >= 3000) begin
         n_cmp++; n_err++;
         $display("FAIL wait_%s: still busy after %0d cycles, required idle", tag, c);
      end
   endtask

   // Reference: bad index aborts with error, zero steps ends clean, otherwise every step runs.
   task automatic issue(input int idx, input int nst, input bit ud, input int cs, input int exact_w);
      exp_t x;
      x.idx = idx; x.ud = ud; x.cs = cs; x.exact_w = exact_w;
      if (idx >= NUM_PLLS) begin x.err = 1; x.sd = 0;   x.pulses = 0;   end
      else if (nst == 0)   begin x.err = 0; x.sd = 0;   x.pulses = 0;   end
      else                 begin x.err = 0; x.sd = nst; x.pulses = nst; end
      @(posedge clk); #1;
      valid = 1'b1; pll_idx = SEL_W'(idx); steps = CNT_W'(nst); updown = ud; cntsel = CNTSEL_W'(cs);
      sb.push_back(x);
      @(posedge clk); #1;
      valid = 1'b0;
      if (x.pulses == 0) begin
         @(negedge clk);
         check("short_done_latency", done, 1);
         check("short_no_step", phasestep, 0);
      end
   endtask

   initial begin
      int c;
      rst = 1'b1; valid = 1'b0; pll_idx = '0; steps = '0; updown = 1'b0; cntsel = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset("reset");

      drop_dly = 3; rise_dly = 4;
      issue(2, 3, 1'b1, 5, 0);
      wait_idle("basic");
      issue(0, 0, 1'b0, 7, 0);
      wait_idle("zero");
      issue(5, 4, 1'b1, 2, 0);
      wait_idle("badidx");

      // phasedone already low when the step starts
      manual_pd = '0; manual_en = 1'b1;
      repeat (4) @(posedge clk);
      issue(1, 1, 1'b0, 3, STEP_HOLD);
      repeat (10) @(posedge clk);
      #1 manual_pd = '1;
      wait_idle("prelow");
      repeat (20) @(posedge clk);
      manual_en = 1'b0;

      // new requests while busy must be ignored
      issue(1, 3, 1'b0, 9, 0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         valid = 1'b1; pll_idx = 3'd3; steps = 8'd7; updown = 1'b1; cntsel = 5'd22;
         @(negedge clk);
         check("ready_while_busy", ready, 0);
      end
      @(posedge clk); #1 valid = 1'b0;
      wait_idle("ignore");

      // reset during step 2 of 5
      issue(3, 5, 1'b1, 17, 0);
      c = 0;
      @(negedge clk);
      while (!(steps_done == 8'd1 && phasestep[3]) && c < 500) begin @(negedge clk); c++; end
      check("reach_step2", (c < 500), 1);
      @(posedge clk); #1 rst = 1'b1; sb.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_reset("midreset");
      repeat (20) @(posedge clk);
      issue(3, 2, 1'b0, 4, 0);
      wait_idle("after_reset");

      for (int r = 0; r < 16; r++) begin
         drop_dly = $urandom_range(1, 5);
         rise_dly = $urandom_range(2, 6);
         issue($urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
               $urandom_range(0, 31), 0);
         wait_idle("random");
      end

`ifdef PHASE_SHIFT_TIMEOUT_EN
      // phasedone stuck high: watchdog aborts the first step
      manual_pd = '1; manual_en = 1'b1;
      @(posedge clk); #1;
      valid = 1'b1; pll_idx = 3'd0; steps = 8'd2; updown = 1'b1; cntsel = 5'd1;
      sb.push_back('{idx: 0, sd: 0, err: 1, ud: 1, cs: 1, pulses: 1, exact_w: 0});
      @(posedge clk); #1 valid = 1'b0;
      c = 1;
      @(negedge clk);
      while (!done && c < 40) begin @(negedge clk); c++; end
      check("timeout_cycle", c, TIMEOUT_CYCLES + 1);
      check("timeout_phasestep", phasestep, 0);
      check("timeout_steps_done", steps_done, 0);
      wait_idle("timeout");
      repeat (20) @(posedge clk);
      manual_en = 1'b0;
`endif

      repeat (5) @(posedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
